// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write arbiter with busy scoreboard
//
// Purpose:
//   Arbitrates register file writes between requester A (ALU writeback) and
//   requester B (load return). At most one transfer is accepted per cycle; on
//   contention, the requester not granted most recently wins. The accepted
//   write reaches the register file one cycle later. A 32-bit scoreboard
//   tracks registers reserved by issue and still awaiting their write.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   aValid     in   1   requester A write pending
//   aDest      in   5   requester A destination register
//   aData      in  32   requester A write data
//   aReady     out  1   requester A granted this cycle
//   bValid     in   1   requester B write pending
//   bDest      in   5   requester B destination register
//   bData      in  32   requester B write data
//   bReady     out  1   requester B granted this cycle
//   rsvValid   in   1   issue reserves a destination register
//   rsvDest    in   5   register being reserved
//   regWrite   out  1   register file write enable
//   destReg    out  5   register file write address
//   writeData  out 32   register file write data
//   busy       out 32   scoreboard, bit n = register n has an outstanding write

module regfile_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        aValid,
    input  logic [4:0]  aDest,
    input  logic [31:0] aData,
    output logic        aReady,
    input  logic        bValid,
    input  logic [4:0]  bDest,
    input  logic [31:0] bData,
    output logic        bReady,
    input  logic        rsvValid,
    input  logic [4:0]  rsvDest,
    output logic        regWrite,
    output logic [4:0]  destReg,
    output logic [31:0] writeData,
    output logic [31:0] busy
);

    // last_grant: 1 = B was granted most recently, 0 = A.
    logic        last_grant_q, last_grant_d;
    logic        reg_write_q,  reg_write_d;
    logic [4:0]  dest_reg_q,   dest_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] busy_q,       busy_d;

    logic        grant_a, grant_b;

    // Readies are gated by reset so nothing is granted while reset is held.
    always_comb begin
        grant_a = reset & aValid & (~bValid | last_grant_q);
        grant_b = reset & bValid & (~aValid | ~last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        dest_reg_d   = dest_reg_q;
        write_data_d = write_data_q;

        if (grant_a) begin
            last_grant_d = 1'b0;
            dest_reg_d   = aDest;
            write_data_d = aData;
            // Handshake completes for r0, but the write itself is dropped.
            reg_write_d  = (aDest != 5'd0);
        end else if (grant_b) begin
            last_grant_d = 1'b1;
            dest_reg_d   = bDest;
            write_data_d = bData;
            reg_write_d  = (bDest != 5'd0);
        end
    end

    // Clear is applied before set so a same-cycle reservation of the bit
    // being written keeps it busy. Clearing an unreserved bit is harmless.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[dest_reg_q] = 1'b0;
        end
        if (rsvValid && (rsvDest != 5'd0)) begin
            busy_d[rsvDest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            reg_write_q  <= 1'b0;
            dest_reg_q   <= 5'd0;
            write_data_q <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            dest_reg_q   <= dest_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        aReady    = grant_a;
        bReady    = grant_b;
        regWrite  = reg_write_q;
        destReg   = dest_reg_q;
        writeData = write_data_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter

module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        aValid, bValid, rsvValid;
    logic [4:0]  aDest, bDest, rsvDest;
    logic [31:0] aData, bData;
    logic        aReady, bReady, regWrite;
    logic [4:0]  destReg;
    logic [31:0] writeData, busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .aValid    (aValid),
        .aDest     (aDest),
        .aData     (aData),
        .aReady    (aReady),
        .bValid    (bValid),
        .bDest     (bDest),
        .bData     (bData),
        .bReady    (bReady),
        .rsvValid  (rsvValid),
        .rsvDest   (rsvDest),
        .regWrite  (regWrite),
        .destReg   (destReg),
        .writeData (writeData),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; checks run 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        aValid   = 1'b1; aDest = 5'd3; aData = 32'h11;
        bValid   = 1'b1; bDest = 5'd4; bData = 32'h22;
        rsvValid = 1'b0; rsvDest = 5'd0;

        // Reset state, with both requesters valid
        step(); step();
        #1;
        check("rst_aReady",    {31'd0, aReady},   32'd0);
        check("rst_bReady",    {31'd0, bReady},   32'd0);
        check("rst_regWrite",  {31'd0, regWrite}, 32'd0);
        check("rst_destReg",   {27'd0, destReg},  32'd0);
        check("rst_writeData", writeData,         32'd0);
        check("rst_busy",      busy,              32'd0);

        // Back-to-back contention: A,B,A,B; writes 3,4,3,4 from the second cycle
        reset = 1'b1;
        #1;
        check("rr0_aReady", {31'd0, aReady}, 32'd1);
        check("rr0_bReady", {31'd0, bReady}, 32'd0);
        check("rr0_regWrite", {31'd0, regWrite}, 32'd0);
        step(); #1;
        check("rr1_aReady", {31'd0, aReady}, 32'd0);
        check("rr1_bReady", {31'd0, bReady}, 32'd1);
        check("rr1_regWrite", {31'd0, regWrite}, 32'd1);
        check("rr1_destReg", {27'd0, destReg}, 32'd3);
        check("rr1_writeData", writeData, 32'h11);
        step(); #1;
        check("rr2_aReady", {31'd0, aReady}, 32'd1);
        check("rr2_regWrite", {31'd0, regWrite}, 32'd1);
        check("rr2_destReg", {27'd0, destReg}, 32'd4);
        check("rr2_writeData", writeData, 32'h22);
        step(); #1;
        check("rr3_bReady", {31'd0, bReady}, 32'd1);
        check("rr3_regWrite", {31'd0, regWrite}, 32'd1);
        check("rr3_destReg", {27'd0, destReg}, 32'd3);
        step(); #1;
        check("rr4_aReady", {31'd0, aReady}, 32'd1);
        check("rr4_regWrite", {31'd0, regWrite}, 32'd1);
        check("rr4_destReg", {27'd0, destReg}, 32'd4);

        // Sole B request for one cycle
        aValid = 1'b0;
        bDest = 5'd7; bData = 32'hDEADBEEF;
        #1;
        check("b_only_bReady", {31'd0, bReady}, 32'd1);
        check("b_only_aReady", {31'd0, aReady}, 32'd0);
        step();
        bValid = 1'b0;
        #1;
        check("b_only_regWrite", {31'd0, regWrite}, 32'd1);
        check("b_only_destReg", {27'd0, destReg}, 32'd7);
        check("b_only_writeData", writeData, 32'hDEADBEEF);
        step(); #1;
        check("idle_regWrite", {31'd0, regWrite}, 32'd0);
        check("idle_destReg_hold", {27'd0, destReg}, 32'd7);
        check("idle_writeData_hold", writeData, 32'hDEADBEEF);

        // Write to r0: handshake completes, no regWrite
        aValid = 1'b1; aDest = 5'd0; aData = 32'hFFFFFFFF;
        #1;
        check("r0_aReady", {31'd0, aReady}, 32'd1);
        step();
        aValid = 1'b0;
        #1;
        check("r0_regWrite", {31'd0, regWrite}, 32'd0);

        // Reservation of r9, then r0 reservation ignored
        rsvValid = 1'b1; rsvDest = 5'd9;
        step();
        rsvDest = 5'd0;
        #1;
        check("rsv9_busy", busy, 32'h0000_0200);
        step();
        rsvValid = 1'b0;
        #1;
        check("rsv0_ignored_busy", busy, 32'h0000_0200);

        // A writes r9: busy clears on the edge ending the regWrite cycle
        aValid = 1'b1; aDest = 5'd9; aData = 32'h99;
        step();
        aValid = 1'b0;
        #1;
        check("w9_regWrite", {31'd0, regWrite}, 32'd1);
        check("w9_destReg", {27'd0, destReg}, 32'd9);
        check("w9_busy_still_set", busy, 32'h0000_0200);
        step(); #1;
        check("w9_busy_cleared", busy, 32'h0000_0000);

        // Set wins: reserve r9 during the cycle that writes r9
        rsvValid = 1'b1; rsvDest = 5'd9;
        step();
        rsvValid = 1'b0;
        aValid = 1'b1; aDest = 5'd9; aData = 32'h98;
        step();
        aValid = 1'b0;
        rsvValid = 1'b1; rsvDest = 5'd9;
        #1;
        check("setwin_regWrite", {31'd0, regWrite}, 32'd1);
        step();
        rsvValid = 1'b0;
        #1;
        check("setwin_busy", busy, 32'h0000_0200);

        // Independent: write r9 while reserving r5
        aValid = 1'b1; aDest = 5'd9; aData = 32'h97;
        step();
        aValid = 1'b0;
        rsvValid = 1'b1; rsvDest = 5'd5;
        step();
        rsvValid = 1'b0;
        #1;
        check("indep_busy", busy, 32'h0000_0020);

        // Write to unreserved r12 leaves busy unchanged
        aValid = 1'b1; aDest = 5'd12; aData = 32'hC;
        step();
        aValid = 1'b0;
        #1;
        check("unrsv_regWrite", {31'd0, regWrite}, 32'd1);
        step(); #1;
        check("unrsv_busy", busy, 32'h0000_0020);

        // Reset between transfer and write: captured write discarded
        aValid = 1'b1; aDest = 5'd6; aData = 32'h66;
        @(posedge clk);
        #2;
        reset  = 1'b0;
        aValid = 1'b0;
        #1;
        check("midrst_regWrite", {31'd0, regWrite}, 32'd0);
        check("midrst_busy", busy, 32'd0);
        step();
        reset = 1'b1;
        step(); #1;
        check("postrst_regWrite", {31'd0, regWrite}, 32'd0);
        check("postrst_busy", busy, 32'd0);
        aValid = 1'b1; aDest = 5'd1; bValid = 1'b1; bDest = 5'd2;
        #1;
        check("postrst_aReady", {31'd0, aReady}, 32'd1);
        check("postrst_bReady", {31'd0, bReady}, 32'd0);
        step(); #1;
        check("postrst_write", {31'd0, regWrite}, 32'd1);
        check("postrst_destReg", {27'd0, destReg}, 32'd1);

        aValid = 1'b0; bValid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
